// File: rtl/gate_check_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
// Shared types and the reference gate function for the gate response checker.
//   op_e     : operation of the two-input gate under test
//   state_e  : checker run state
//   gate_ref : golden output of a two-input gate for a given operation
// -----------------------------------------------------------------------------
package gate_check_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // All four {X,Y} input combinations observed
    localparam logic [3:0] COV_FULL = 4'b1111;

    // Golden response of the selected two-input gate
    function automatic logic gate_ref(input op_e op, input logic x, input logic y);
        logic res;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            OP_NAND: res = ~(x & y);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // One-hot coverage bit for the {X,Y} input combination
    function automatic logic [3:0] cov_bit(input logic x, input logic y);
        logic [3:0] res;
        case ({x, y})
            2'b00:   res = 4'b0001;
            2'b01:   res = 4'b0010;
            2'b10:   res = 4'b0100;
            2'b11:   res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
// Combinational reference model of a two-input gate, shared by the checker and
// any stimulus generator that needs the expected response.
//   i_op  : gate operation (op_e)
//   i_x   : gate input X
//   i_y   : gate input Y
//   o_out : expected gate output
// -----------------------------------------------------------------------------
module gate_ref_model
    import gate_check_pkg::*;
(
    input  op_e  i_op,
    input  logic i_x,
    input  logic i_y,
    output logic o_out
);

    // Expected output straight from the package reference function
    always_comb begin
        o_out = gate_ref(i_op, i_x, i_y);
    end

endmodule

// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
// Judges the sampled response of a two-input gate against the reference model,
// counting samples and mismatches, tracking truth-table coverage and reporting
// pass/fail once a run is stopped.
//   i_clk          : rising-edge clock
//   i_rst_n        : synchronous active-low reset
//   i_start        : pulse, clears results, latches i_op, enters RUN
//   i_op           : gate operation (0 AND, 1 OR, 2 XOR, 3 NAND)
//   i_sample_valid : i_x/i_y/i_out carry a valid DUT sample
//   i_x, i_y       : DUT inputs
//   i_out          : DUT output
//   i_stop         : pulse, ends the run
//   o_busy         : run in progress
//   o_done         : run finished, results frozen
//   o_pass         : no errors and full coverage (valid while o_done)
//   o_sample_cnt   : accepted samples, saturating
//   o_err_cnt      : mismatching samples, saturating
//   o_coverage     : bit {X,Y} set once that combination was seen
//   o_first_err    : {X,Y,OUT} of the first mismatch
//   o_err_pulse    : one-cycle flag for a mismatch on the previous sample
// -----------------------------------------------------------------------------
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_sample_valid,
    input  logic             i_x,
    input  logic             i_y,
    input  logic             i_out,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [3:0]       o_coverage,
    output logic [2:0]       o_first_err,
    output logic             o_err_pulse
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    op_e              r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [3:0]       r_cov;
    logic [2:0]       r_first_err;
    logic             r_first_seen;
    logic             r_err_pulse;

    logic             w_expected;
    logic             w_accept;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_sample_cnt_nxt;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [3:0]       w_cov_nxt;
    logic [2:0]       w_first_err_nxt;
    logic             w_first_seen_nxt;
    logic             w_pass_nxt;

    gate_ref_model u_ref (
        .i_op  (r_op),
        .i_x   (i_x),
        .i_y   (i_y),
        .o_out (w_expected)
    );

    // Sample acceptance: only in RUN, and a restart discards the same-cycle sample
    always_comb begin
        w_accept   = i_sample_valid && (r_state == S_RUN) && !i_start;
        w_mismatch = w_accept && (i_out != w_expected);
    end

    // Next result values including the current sample, so a sample arriving
    // together with STOP is already part of the PASS decision
    always_comb begin
        w_sample_cnt_nxt = r_sample_cnt;
        w_err_cnt_nxt    = r_err_cnt;
        w_cov_nxt        = r_cov;
        w_first_err_nxt  = r_first_err;
        w_first_seen_nxt = r_first_seen;
        if (w_accept) begin
            if (r_sample_cnt != CNT_MAX) begin
                w_sample_cnt_nxt = r_sample_cnt + CNT_ONE;
            end else begin
                w_sample_cnt_nxt = r_sample_cnt;
            end
            w_cov_nxt = r_cov | cov_bit(i_x, i_y);
            if (w_mismatch) begin
                if (r_err_cnt != CNT_MAX) begin
                    w_err_cnt_nxt = r_err_cnt + CNT_ONE;
                end else begin
                    w_err_cnt_nxt = r_err_cnt;
                end
                if (!r_first_seen) begin
                    w_first_err_nxt  = {i_x, i_y, i_out};
                    w_first_seen_nxt = 1'b1;
                end else begin
                    w_first_err_nxt  = r_first_err;
                    w_first_seen_nxt = r_first_seen;
                end
            end else begin
                w_err_cnt_nxt = r_err_cnt;
            end
        end else begin
            w_sample_cnt_nxt = r_sample_cnt;
            w_cov_nxt        = r_cov;
        end
        w_pass_nxt = (w_err_cnt_nxt == CNT_ZERO) && (w_cov_nxt == COV_FULL);
    end

    // Run FSM with registered status outputs and result registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_AND;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_sample_cnt <= CNT_ZERO;
            r_err_cnt    <= CNT_ZERO;
            r_cov        <= 4'b0000;
            r_first_err  <= 3'b000;
            r_first_seen <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else if (i_start) begin
            // START from any state (priority over STOP) clears and re-arms the run
            r_state      <= S_RUN;
            r_op         <= op_e'(i_op);
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_sample_cnt <= CNT_ZERO;
            r_err_cnt    <= CNT_ZERO;
            r_cov        <= 4'b0000;
            r_first_err  <= 3'b000;
            r_first_seen <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_IDLE;
                    r_err_pulse <= 1'b0;
                end
                S_RUN: begin
                    r_sample_cnt <= w_sample_cnt_nxt;
                    r_err_cnt    <= w_err_cnt_nxt;
                    r_cov        <= w_cov_nxt;
                    r_first_err  <= w_first_err_nxt;
                    r_first_seen <= w_first_seen_nxt;
                    r_err_pulse  <= w_mismatch;
                    if (i_stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_pass_nxt;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    // Results frozen; only a START leaves this state
                    r_state     <= S_DONE;
                    r_err_pulse <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_pass      <= 1'b0;
                    r_err_pulse <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        o_busy       = r_busy;
        o_done       = r_done;
        o_pass       = r_pass;
        o_sample_cnt = r_sample_cnt;
        o_err_cnt    = r_err_cnt;
        o_coverage   = r_cov;
        o_first_err  = r_first_err;
        o_err_pulse  = r_err_pulse;
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
// Directed bench for gate_response_checker. Two instances share all inputs:
// one with the default 16-bit counters and one with 4-bit counters for the
// saturation case.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        sample_valid;
    logic        x;
    logic        y;
    logic        out;
    logic        stop;

    logic        busy16, done16, pass16, pulse16;
    logic [15:0] scnt16, ecnt16;
    logic [3:0]  cov16;
    logic [2:0]  ferr16;

    logic        busy4, done4, pass4, pulse4;
    logic [3:0]  scnt4, ecnt4;
    logic [3:0]  cov4;
    logic [2:0]  ferr4;

    int n_checks = 0;
    int n_errors = 0;
    logic pulse_seen;

    gate_response_checker #(.CNT_W(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_sample_valid(sample_valid), .i_x(x), .i_y(y), .i_out(out), .i_stop(stop),
        .o_busy(busy16), .o_done(done16), .o_pass(pass16),
        .o_sample_cnt(scnt16), .o_err_cnt(ecnt16), .o_coverage(cov16),
        .o_first_err(ferr16), .o_err_pulse(pulse16)
    );

    gate_response_checker #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_sample_valid(sample_valid), .i_x(x), .i_y(y), .i_out(out), .i_stop(stop),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4),
        .o_sample_cnt(scnt4), .o_err_cnt(ecnt4), .o_coverage(cov4),
        .o_first_err(ferr4), .o_err_pulse(pulse4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
        pulse_seen = pulse_seen | pulse16;
    endtask

    task automatic do_start(input logic [1:0] o);
        start = 1'b1;
        op    = o;
        step();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic sx, input logic sy, input logic so);
        sample_valid = 1'b1;
        x = sx; y = sy; out = so;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, busy16},  32'd0);
        check_eq({tag, "_done"},  {31'd0, done16},  32'd0);
        check_eq({tag, "_pass"},  {31'd0, pass16},  32'd0);
        check_eq({tag, "_scnt"},  {16'd0, scnt16},  32'd0);
        check_eq({tag, "_ecnt"},  {16'd0, ecnt16},  32'd0);
        check_eq({tag, "_cov"},   {28'd0, cov16},   32'd0);
        check_eq({tag, "_ferr"},  {29'd0, ferr16},  32'd0);
        check_eq({tag, "_pulse"}, {31'd0, pulse16}, 32'd0);
        check_eq({tag, "_scnt4"}, {28'd0, scnt4},   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; sample_valid = 1'b0;
        x = 1'b0; y = 1'b0; out = 1'b0; stop = 1'b0; pulse_seen = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // IDLE ignores STOP and samples
        stop = 1'b1;
        do_sample(1'b1, 1'b1, 1'b0);
        stop = 1'b0;
        check_all_zero("idle_ignore");

        // OR, all combos correct
        do_start(2'd1);
        check_eq("or_start_busy", {31'd0, busy16}, 32'd1);
        pulse_seen = 1'b0;
        do_sample(1'b0, 1'b0, 1'b0);
        do_sample(1'b0, 1'b1, 1'b1);
        do_sample(1'b1, 1'b0, 1'b1);
        do_sample(1'b1, 1'b1, 1'b1);
        do_stop();
        check_eq("or_scnt", {16'd0, scnt16}, 32'd4);
        check_eq("or_ecnt", {16'd0, ecnt16}, 32'd0);
        check_eq("or_cov",  {28'd0, cov16},  32'hF);
        check_eq("or_done", {31'd0, done16}, 32'd1);
        check_eq("or_busy", {31'd0, busy16}, 32'd0);
        check_eq("or_pass", {31'd0, pass16}, 32'd1);
        check_eq("or_no_pulse", {31'd0, pulse_seen}, 32'd0);

        // OR with two bad samples
        do_start(2'd1);
        check_eq("or2_clear_done", {31'd0, done16}, 32'd0);
        check_eq("or2_clear_pass", {31'd0, pass16}, 32'd0);
        do_sample(1'b0, 1'b1, 1'b0);
        check_eq("or2_pulse1", {31'd0, pulse16}, 32'd1);
        check_eq("or2_ferr1",  {29'd0, ferr16},  32'b010);
        step();
        check_eq("or2_pulse_off", {31'd0, pulse16}, 32'd0);
        do_sample(1'b1, 1'b1, 1'b0);
        check_eq("or2_pulse2", {31'd0, pulse16}, 32'd1);
        do_stop();
        check_eq("or2_ecnt", {16'd0, ecnt16}, 32'd2);
        check_eq("or2_ferr", {29'd0, ferr16}, 32'b010);
        check_eq("or2_pass", {31'd0, pass16}, 32'd0);
        check_eq("or2_pulse_end", {31'd0, pulse16}, 32'd0);

        // XOR, incomplete coverage
        do_start(2'd2);
        do_sample(1'b0, 1'b0, 1'b0);
        do_sample(1'b1, 1'b1, 1'b0);
        do_stop();
        check_eq("xor_ecnt", {16'd0, ecnt16}, 32'd0);
        check_eq("xor_cov",  {28'd0, cov16},  32'b1001);
        check_eq("xor_pass", {31'd0, pass16}, 32'd0);
        check_eq("xor_done", {31'd0, done16}, 32'd1);

        // AND, sample together with STOP, then samples in DONE
        do_start(2'd0);
        stop = 1'b1;
        do_sample(1'b1, 1'b0, 1'b1);
        stop = 1'b0;
        check_eq("and_stop_done",  {31'd0, done16},  32'd1);
        check_eq("and_stop_scnt",  {16'd0, scnt16},  32'd1);
        check_eq("and_stop_ecnt",  {16'd0, ecnt16},  32'd1);
        check_eq("and_stop_pulse", {31'd0, pulse16}, 32'd1);
        check_eq("and_stop_ferr",  {29'd0, ferr16},  32'b101);
        do_sample(1'b1, 1'b1, 1'b0);
        do_sample(1'b0, 1'b0, 1'b1);
        check_eq("done_frz_scnt", {16'd0, scnt16}, 32'd1);
        check_eq("done_frz_ecnt", {16'd0, ecnt16}, 32'd1);
        check_eq("done_frz_cov",  {28'd0, cov16},  32'b0100);
        check_eq("done_frz_pulse", {31'd0, pulse16}, 32'd0);
        check_eq("done_frz_done", {31'd0, done16}, 32'd1);

        // Restart mid-run: START + STOP + sample in the same cycle
        do_start(2'd0);
        do_sample(1'b0, 1'b0, 1'b0);
        do_sample(1'b0, 1'b1, 1'b0);
        do_sample(1'b1, 1'b1, 1'b1);
        check_eq("rs_pre_scnt", {16'd0, scnt16}, 32'd3);
        start = 1'b1; op = 2'd2; stop = 1'b1;
        do_sample(1'b1, 1'b1, 1'b0);
        start = 1'b0; stop = 1'b0;
        check_eq("rs_busy", {31'd0, busy16}, 32'd1);
        check_eq("rs_done", {31'd0, done16}, 32'd0);
        check_eq("rs_scnt", {16'd0, scnt16}, 32'd0);
        check_eq("rs_cov",  {28'd0, cov16},  32'd0);
        // XOR now latched: 01 -> 1 is correct, 11 -> 1 is wrong
        do_sample(1'b0, 1'b1, 1'b1);
        check_eq("rs_xor_ok", {16'd0, ecnt16}, 32'd0);
        do_sample(1'b1, 1'b1, 1'b1);
        check_eq("rs_xor_bad", {16'd0, ecnt16}, 32'd1);
        check_eq("rs_xor_ferr", {29'd0, ferr16}, 32'b111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_all_zero("midrun_rst");

        // NAND, all combos correct
        do_start(2'd3);
        do_sample(1'b0, 1'b0, 1'b1);
        do_sample(1'b0, 1'b1, 1'b1);
        do_sample(1'b1, 1'b0, 1'b1);
        do_sample(1'b1, 1'b1, 1'b0);
        do_stop();
        check_eq("nand_ecnt", {16'd0, ecnt16}, 32'd0);
        check_eq("nand_pass", {31'd0, pass16}, 32'd1);

        // Saturation: 20 back-to-back wrong samples under OR
        do_start(2'd1);
        sample_valid = 1'b1; x = 1'b0; y = 1'b0; out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        sample_valid = 1'b0;
        do_stop();
        check_eq("sat4_scnt",  {28'd0, scnt4},  32'd15);
        check_eq("sat4_ecnt",  {28'd0, ecnt4},  32'd15);
        check_eq("sat4_pass",  {31'd0, pass4},  32'd0);
        check_eq("sat4_done",  {31'd0, done4},  32'd1);
        check_eq("sat4_ferr",  {29'd0, ferr4},  32'b001);
        check_eq("sat16_scnt", {16'd0, scnt16}, 32'd20);
        check_eq("sat16_ecnt", {16'd0, ecnt16}, 32'd20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
